// File: rtl/bank_timed.sv
// -----------------------------------------------------------------------------
// bank_timed
// Cycle-accurate model of one DRAM bank: page storage in BRAM, ACT/RD/WR/PR/REF
// timing enforced by an internal state machine, open-row tracking,
// auto-precharge, refresh, wrapped bursts and illegal-command flagging.
//
// Ports:
//   clk, reset_n        single clock, asynchronous active-low reset
//   halt                freezes FSM, counters, outputs and BRAM writes
//   cmd_valid, cmd      command strobe and code (NOP/ACT/RD/RDA/WR/WRA/PR/REF)
//   row                 row address, sampled with ACT
//   column              start column, sampled with RD/RDA/WR/WRA
//   wdata               write beat data
//   rdata, rdata_valid  registered read beat data and qualifier
//   cmd_ready           bank can accept a command this cycle
//   row_open, open_row  active-row status and address
//   illegal             one-cycle pulse after a rejected command
// -----------------------------------------------------------------------------
module bank_timed #(
    parameter int WIDTH      = 4,
    parameter int ROWS       = 131072,
    parameter int COLS       = 1024,
    parameter int BL         = 8,
    parameter int ROWSINSRAM = 32,
    parameter int TRCD       = 14,
    parameter int TRP        = 14,
    parameter int TCL        = 14,
    parameter int TCWL       = 10,
    parameter int TWR        = 15,
    parameter int TRFC       = 350
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      halt,
    input  logic                      cmd_valid,
    input  logic [2:0]                cmd,
    input  logic [$clog2(ROWS)-1:0]   row,
    input  logic [$clog2(COLS)-1:0]   column,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic                      rdata_valid,
    output logic                      cmd_ready,
    output logic                      row_open,
    output logic [$clog2(ROWS)-1:0]   open_row,
    output logic                      illegal
);

    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int BW    = $clog2(BL);
    localparam int SW    = $clog2(ROWSINSRAM);
    localparam int AW    = SW + CW;
    localparam int DEPTH = ROWSINSRAM * COLS;

    localparam int TM0   = (TRCD > TRP)  ? TRCD : TRP;
    localparam int TM1   = (TCL  > TCWL) ? TCL  : TCWL;
    localparam int TM2   = (TWR  > TRFC) ? TWR  : TRFC;
    localparam int TM3   = (TM0  > TM1)  ? TM0  : TM1;
    localparam int TMAX  = (TM3  > TM2)  ? TM3  : TM2;
    localparam int CNT_W = $clog2(TMAX + 1);

    // A state entered directly from an accepted command already spent cycle 0
    // in IDLE/ACTIVE, so it lasts T-1 cycles; a state entered from a burst or
    // recovery lasts the full T cycles.
    localparam logic [CNT_W-1:0] LD_TRCD = CNT_W'(TRCD - 2);
    localparam logic [CNT_W-1:0] LD_TCL  = CNT_W'(TCL - 2);
    localparam logic [CNT_W-1:0] LD_TCWL = CNT_W'(TCWL - 2);
    localparam logic [CNT_W-1:0] LD_TRFC = CNT_W'(TRFC - 2);
    localparam logic [CNT_W-1:0] LD_PR   = CNT_W'(TRP - 2);
    localparam logic [CNT_W-1:0] LD_APR  = CNT_W'(TRP - 1);
    localparam logic [CNT_W-1:0] LD_TWR  = CNT_W'(TWR - 1);
    localparam logic [BW-1:0]    BEAT_LAST = BW'(BL - 1);

    typedef enum logic [2:0] {
        C_NOP = 3'd0,
        C_ACT = 3'd1,
        C_RD  = 3'd2,
        C_RDA = 3'd3,
        C_WR  = 3'd4,
        C_WRA = 3'd5,
        C_PR  = 3'd6,
        C_REF = 3'd7
    } cmd_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACTIVATING,
        S_ACTIVE,
        S_RD_LAT,
        S_RD_BURST,
        S_WR_LAT,
        S_WR_BURST,
        S_WR_RECOV,
        S_PRECHARGING,
        S_REFRESHING
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [CW-1:0]     col_q, col_d;
    logic              auto_q, auto_d;
    logic [RW-1:0]     open_row_q, open_row_d;
    logic              row_open_q, row_open_d;
    logic              illegal_q, illegal_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic [WIDTH-1:0]  rdata_q;

    cmd_e              cmd_in;
    logic              cmd_go;
    logic              rd_en;
    logic              wr_en;
    logic [BW-1:0]     rd_beat;
    logic [CW-1:0]     rd_col;
    logic [CW-1:0]     wr_col;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     wr_addr;

    logic [WIDTH-1:0]  mem [DEPTH];

    assign cmd_in = cmd_e'(cmd);
    assign cmd_go = cmd_valid && (cmd_in != C_NOP);

    // State register: every flop freezes while halt is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            beat_q        <= '0;
            col_q         <= '0;
            auto_q        <= 1'b0;
            open_row_q    <= '0;
            row_open_q    <= 1'b0;
            illegal_q     <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else if (!halt) begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            beat_q        <= beat_d;
            col_q         <= col_d;
            auto_q        <= auto_d;
            open_row_q    <= open_row_d;
            row_open_q    <= row_open_d;
            illegal_q     <= illegal_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        col_d      = col_q;
        auto_d     = auto_q;
        open_row_d = open_row_q;
        row_open_d = row_open_q;
        illegal_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_go) begin
                    case (cmd_in)
                        C_ACT: begin
                            state_d    = S_ACTIVATING;
                            cnt_d      = LD_TRCD;
                            open_row_d = row;
                            row_open_d = 1'b1;
                        end
                        C_REF: begin
                            state_d = S_REFRESHING;
                            cnt_d   = LD_TRFC;
                        end
                        C_PR:    ;
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            S_ACTIVE: begin
                if (cmd_go) begin
                    case (cmd_in)
                        C_RD, C_RDA: begin
                            state_d = S_RD_LAT;
                            cnt_d   = LD_TCL;
                            beat_d  = '0;
                            col_d   = column;
                            auto_d  = (cmd_in == C_RDA);
                        end
                        C_WR, C_WRA: begin
                            state_d = S_WR_LAT;
                            cnt_d   = LD_TCWL;
                            beat_d  = '0;
                            col_d   = column;
                            auto_d  = (cmd_in == C_WRA);
                        end
                        C_PR: begin
                            state_d = S_PRECHARGING;
                            cnt_d   = LD_PR;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            S_ACTIVATING: begin
                illegal_d = cmd_go;
                if (cnt_q == '0) state_d = S_ACTIVE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RD_LAT: begin
                illegal_d = cmd_go;
                if (cnt_q == '0) begin
                    state_d = S_RD_BURST;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RD_BURST: begin
                illegal_d = cmd_go;
                if (beat_q == BEAT_LAST) begin
                    if (auto_q) begin
                        state_d = S_PRECHARGING;
                        cnt_d   = LD_APR;
                    end else begin
                        state_d = S_ACTIVE;
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_WR_LAT: begin
                illegal_d = cmd_go;
                if (cnt_q == '0) begin
                    state_d = S_WR_BURST;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WR_BURST: begin
                illegal_d = cmd_go;
                if (beat_q == BEAT_LAST) begin
                    state_d = S_WR_RECOV;
                    cnt_d   = LD_TWR;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_WR_RECOV: begin
                illegal_d = cmd_go;
                if (cnt_q == '0) begin
                    if (auto_q) begin
                        state_d = S_PRECHARGING;
                        cnt_d   = LD_APR;
                    end else begin
                        state_d = S_ACTIVE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PRECHARGING: begin
                illegal_d = cmd_go;
                if (cnt_q == '0) begin
                    state_d    = S_IDLE;
                    row_open_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_REFRESHING: begin
                illegal_d = cmd_go;
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / BRAM-control logic. The read for beat k is issued one cycle
    // ahead of its output cycle to cover the registered BRAM read: beat 0 in
    // the last RD_LAT cycle, beat k+1 while beat k is on rdata.
    always_comb begin
        cmd_ready = ((state_q == S_IDLE) || (state_q == S_ACTIVE)) && !halt;

        rd_en   = 1'b0;
        rd_beat = '0;
        if (!halt) begin
            if ((state_q == S_RD_LAT) && (cnt_q == '0)) begin
                rd_en = 1'b1;
            end else if ((state_q == S_RD_BURST) && (beat_q != BEAT_LAST)) begin
                rd_en   = 1'b1;
                rd_beat = beat_q + 1'b1;
            end
        end
        wr_en = !halt && (state_q == S_WR_BURST);

        // Burst wraps inside the BL-aligned column block.
        rd_col         = col_q;
        rd_col[BW-1:0] = col_q[BW-1:0] + rd_beat;
        wr_col         = col_q;
        wr_col[BW-1:0] = col_q[BW-1:0] + beat_q;

        rd_addr = {open_row_q[SW-1:0], rd_col};
        wr_addr = {open_row_q[SW-1:0], wr_col};

        rdata_valid_d = rd_en;
    end

    // Page storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[rd_addr];
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign row_open    = row_open_q;
    assign open_row    = open_row_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_bank_timed.sv
// -----------------------------------------------------------------------------
// tb_bank_timed
// Directed bench for bank_timed at default parameters: a table of command
// vectors with hand-computed responses, followed by hand-written sequences for
// bursts, wrap, auto-precharge, halt and reset.
// -----------------------------------------------------------------------------
module tb_bank_timed;

    localparam int WIDTH = 4, ROWS = 131072, COLS = 1024, BL = 8, ROWSINSRAM = 32;
    localparam int TRCD = 14, TRP = 14, TCL = 14, TCWL = 10, TWR = 15, TRFC = 350;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, RDA = 3'd3;
    localparam logic [2:0] WR  = 3'd4, WRA = 3'd5, PR = 3'd6, REF = 3'd7;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             halt = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [2:0]       cmd = 3'd0;
    logic [RW-1:0]    row = '0;
    logic [CW-1:0]    column = '0;
    logic [WIDTH-1:0] wdata = '0;
    logic [WIDTH-1:0] rdata;
    logic             rdata_valid;
    logic             cmd_ready;
    logic             row_open;
    logic [RW-1:0]    open_row;
    logic             illegal;

    int tests = 0;
    int fails = 0;

    int rd_first, rd_last, rd_cnt, rd_ready;
    int rd_data [16];

    bank_timed #(
        .WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .BL(BL), .ROWSINSRAM(ROWSINSRAM),
        .TRCD(TRCD), .TRP(TRP), .TCL(TCL), .TCWL(TCWL), .TWR(TWR), .TRFC(TRFC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .halt(halt), .cmd_valid(cmd_valid),
        .cmd(cmd), .row(row), .column(column), .wdata(wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .cmd_ready(cmd_ready),
        .row_open(row_open), .open_row(open_row), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drive a command for one cycle; returns at the negedge of cycle 1.
    task automatic issue(input logic [2:0] c, input int r, input int col);
        cmd_valid = (c != NOP);
        cmd       = c;
        row       = RW'(r);
        column    = CW'(col);
        step();
        cmd_valid = 1'b0;
        cmd       = NOP;
    endtask

    // Steps until cmd_ready is high; reports the cycle index or -1 on timeout.
    task automatic wait_ready(input int start, input int limit, output int at);
        at = -1;
        for (int c = start; c <= limit; c++) begin
            if (cmd_ready) begin
                at = c;
                break;
            end
            step();
        end
    endtask

    // Write burst; returns at the negedge of cycle TCWL+BL.
    task automatic do_write(input logic [2:0] c, input int col, input int base);
        issue(c, 0, col);
        repeat (TCWL - 1) step();
        for (int k = 0; k < BL; k++) begin
            wdata = WIDTH'(base + k);
            step();
        end
    endtask

    // Read burst, capturing beats and timing; returns at cycle limit+1.
    task automatic do_read(input int col, input int limit);
        rd_first = -1; rd_last = -1; rd_cnt = 0; rd_ready = -1;
        issue(RD, 0, col);
        for (int cy = 1; cy <= limit; cy++) begin
            if (rdata_valid) begin
                if (rd_cnt == 0) rd_first = cy;
                if (rd_cnt < 16) rd_data[rd_cnt] = int'(rdata);
                rd_cnt++;
                rd_last = cy;
            end
            if (cmd_ready && rd_ready < 0) rd_ready = cy;
            step();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rdata"}, int'(rdata), 0);
        chk({tag, " rdata_valid"}, int'(rdata_valid), 0);
        chk({tag, " row_open"}, int'(row_open), 0);
        chk({tag, " open_row"}, int'(open_row), 0);
        chk({tag, " illegal"}, int'(illegal), 0);
        chk({tag, " cmd_ready"}, int'(cmd_ready), 1);
    endtask

    typedef struct {
        logic [2:0] c;
        int         r;
        int         wait_n;
        logic       exp_ill;
        logic       exp_ready;
        logic       exp_ro;
        logic       chk_or;
        int         exp_or;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int at;
    int h_ready;
    int w_ready;
    int w_closed;
    int e;
    logic hnow;

    initial begin
        // cmd, row, wait, illegal, ready, row_open, check open_row, open_row
        vecs[0]  = '{RD,  0, 1,   1'b1, 1'b1, 1'b0, 1'b1, 0};  // RD in IDLE
        vecs[1]  = '{PR,  0, 1,   1'b0, 1'b1, 1'b0, 1'b1, 0};  // PR in IDLE is a NOP
        vecs[2]  = '{ACT, 5, 1,   1'b0, 1'b0, 1'b1, 1'b1, 5};
        vecs[3]  = '{REF, 0, 1,   1'b1, 1'b0, 1'b1, 1'b1, 5};  // REF while activating
        vecs[4]  = '{NOP, 0, 11,  1'b0, 1'b0, 1'b1, 1'b1, 5};  // ACT cycle 13
        vecs[5]  = '{NOP, 0, 1,   1'b0, 1'b1, 1'b1, 1'b1, 5};  // ACT cycle 14
        vecs[6]  = '{ACT, 9, 1,   1'b1, 1'b1, 1'b1, 1'b1, 5};  // ACT with row open
        vecs[7]  = '{REF, 0, 1,   1'b1, 1'b1, 1'b1, 1'b1, 5};  // REF with row open
        vecs[8]  = '{PR,  0, 13,  1'b0, 1'b0, 1'b1, 1'b1, 5};  // PR cycle 13
        vecs[9]  = '{NOP, 0, 1,   1'b0, 1'b1, 1'b0, 1'b0, 0};  // PR cycle 14
        vecs[10] = '{REF, 0, 349, 1'b0, 1'b0, 1'b0, 1'b0, 0};  // REF cycle 349
        vecs[11] = '{ACT, 7, 1,   1'b1, 1'b1, 1'b0, 1'b0, 0};  // ACT at 349, ready at 350
        vecs[12] = '{ACT, 7, 1,   1'b0, 1'b0, 1'b1, 1'b1, 7};  // ACT at 350 accepted

        // Reset state.
        step();
        step();
        chk_reset_vals("in_reset");
        reset_n = 1'b1;
        step();
        chk_reset_vals("after_reset");

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].c, vecs[i].r, 0);
            chk($sformatf("v%0d illegal", i), int'(illegal), int'(vecs[i].exp_ill));
            repeat (vecs[i].wait_n - 1) step();
            chk($sformatf("v%0d cmd_ready", i), int'(cmd_ready), int'(vecs[i].exp_ready));
            chk($sformatf("v%0d row_open", i), int'(row_open), int'(vecs[i].exp_ro));
            if (vecs[i].chk_or)
                chk($sformatf("v%0d open_row", i), int'(open_row), vecs[i].exp_or);
        end

        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        // Basic write/read.
        issue(ACT, 5, 0);
        wait_ready(1, 40, at);
        chk("act ready cycle", at, TRCD);
        do_write(WR, 0, 0);
        wait_ready(TCWL + BL, 80, at);
        chk("wr ready cycle", at, TCWL + BL + TWR);
        do_read(0, 30);
        chk("rd first valid", rd_first, TCL);
        chk("rd last valid", rd_last, TCL + BL - 1);
        chk("rd valid count", rd_cnt, BL);
        chk("rd ready cycle", rd_ready, TCL + BL);
        for (int k = 0; k < BL; k++) chk($sformatf("rd beat%0d", k), rd_data[k], k);

        // Wrapped burst.
        do_write(WR, 8, 0);
        wait_ready(TCWL + BL, 80, at);
        chk("wr2 ready cycle", at, TCWL + BL + TWR);
        do_read(13, 30);
        chk("wrap valid count", rd_cnt, BL);
        for (int k = 0; k < BL; k++) chk($sformatf("wrap beat%0d", k), rd_data[k], (5 + k) % 8);

        // Halt for 5 cycles in the middle of a read burst, with a command under halt.
        issue(RD, 0, 0);
        h_ready = -1;
        for (int cy = 1; cy <= 40; cy++) begin
            e    = (cy <= 17) ? cy : ((cy <= 22) ? 17 : cy - 5);
            hnow = (cy >= 18) && (cy <= 22);
            chk($sformatf("halt c%0d valid", cy), int'(rdata_valid),
                int'(e >= TCL && e <= TCL + BL - 1));
            if (e >= TCL && e <= TCL + BL - 1)
                chk($sformatf("halt c%0d rdata", cy), int'(rdata), e - TCL);
            chk($sformatf("halt c%0d ready", cy), int'(cmd_ready), int'(!hnow && e >= TCL + BL));
            chk($sformatf("halt c%0d illegal", cy), int'(illegal), 0);
            if (cmd_ready && h_ready < 0) h_ready = cy;
            if (cy == 17) begin
                halt = 1'b1;
                cmd_valid = 1'b1;
                cmd = RD;
            end
            if (cy == 18) begin
                cmd_valid = 1'b0;
                cmd = NOP;
            end
            if (cy == 22) halt = 1'b0;
            step();
        end
        chk("halt ready delayed", h_ready, TCL + BL + 5);

        // Write with auto-precharge.
        do_write(WRA, 16, 9);
        w_ready = -1;
        w_closed = -1;
        for (int cy = TCWL + BL; cy <= 60; cy++) begin
            if (cmd_ready && w_ready < 0) w_ready = cy;
            if (!row_open && w_closed < 0) w_closed = cy;
            step();
        end
        chk("wra ready cycle", w_ready, TCWL + BL + TWR + TRP);
        chk("wra row_open fall", w_closed, TCWL + BL + TWR + TRP);
        issue(RD, 0, 0);
        chk("rd after wra illegal", int'(illegal), 1);
        chk("rd after wra ready", int'(cmd_ready), 1);
        issue(ACT, 5, 0);
        chk("act after wra illegal", int'(illegal), 0);
        chk("act after wra ready", int'(cmd_ready), 0);
        chk("act after wra row_open", int'(row_open), 1);
        wait_ready(1, 40, at);
        chk("act2 ready cycle", at, TRCD);

        // Reset in the middle of a read burst.
        issue(RD, 0, 0);
        repeat (16) step();
        chk("pre-reset valid", int'(rdata_valid), 1);
        chk("pre-reset rdata", int'(rdata), 3);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        step();
        reset_n = 1'b1;
        step();
        chk("post-reset ready", int'(cmd_ready), 1);

        // Aliased row 37 -> BRAM row 5; write interrupted by reset after 3 beats.
        issue(ACT, 37, 0);
        wait_ready(1, 40, at);
        chk("act37 ready cycle", at, TRCD);
        chk("act37 open_row", int'(open_row), 37);
        issue(WR, 0, 24);
        repeat (TCWL - 1) step();
        for (int k = 0; k < 3; k++) begin
            wdata = WIDTH'(1 + k);
            step();
        end
        wdata = WIDTH'(15);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        issue(ACT, 5, 0);
        wait_ready(1, 40, at);
        chk("act3 ready cycle", at, TRCD);
        do_read(8, 30);
        chk("kept valid count", rd_cnt, BL);
        for (int k = 0; k < BL; k++) chk($sformatf("kept beat%0d", k), rd_data[k], k);
        do_read(16, 30);
        for (int k = 0; k < BL; k++) chk($sformatf("wra beat%0d", k), rd_data[k], (9 + k) % 16);
        do_read(24, 30);
        chk("partial valid count", rd_cnt, BL);
        for (int k = 0; k < 3; k++) chk($sformatf("partial beat%0d", k), rd_data[k], 1 + k);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
